// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between mem_stage and the data memory.
// master: the pipeline stage issuing requests; slave: the memory answering them.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wmask;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Non-memory results pass through one register; loads/stores run a
// request/ack transaction on the dmem bus, with load data lane-shifted,
// truncated and sign/zero-extended.
// Optional feature: define MEM_STAGE_MISALIGN_CHK_EN to flag misaligned
// accesses (no request, mem_misalign pulse). Without it every memory op is
// issued and lanes shifted past byte 7 are simply dropped.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] exe_result,
   input  logic [63:0] store_data,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [4:0]  rd_addr,
   input  logic        rd_wen,
   mem_stage_if.master dmem,
   output logic        wb_valid,
   output logic [4:0]  wb_rd_addr,
   output logic        wb_rd_wen,
   output logic [63:0] wb_rd_data,
   output logic        mem_misalign
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_reg, state_next;

   // Memory transaction registers (drive the dmem bus directly)
   logic        req_reg, req_next;
   logic        we_reg, we_next;
   logic [63:0] addr_reg, addr_next;
   logic [63:0] wdata_reg, wdata_next;
   logic [7:0]  wmask_reg, wmask_next;

   // Fields latched at accept, needed when the ack returns
   logic [2:0]  off_reg, off_next;
   logic [1:0]  size_reg, size_next;
   logic        uns_reg, uns_next;
   logic [4:0]  rd_addr_reg, rd_addr_next;
   logic        rd_wen_reg, rd_wen_next;

   // Writeback registers
   logic        wb_valid_reg, wb_valid_next;
   logic [4:0]  wb_rd_addr_reg, wb_rd_addr_next;
   logic        wb_rd_wen_reg, wb_rd_wen_next;
   logic [63:0] wb_rd_data_reg, wb_rd_data_next;
   logic        misalign_reg, misalign_next;

   logic        is_mem;
   logic        misaligned;
   logic [7:0]  size_mask;
   logic [7:0]  wmask_calc;
   logic [63:0] wdata_calc;
   logic [63:0] rdata_shifted;
   logic [63:0] ext_data [4];
   logic [63:0] load_data;

   assign is_mem     = mem_ren | mem_wen;
   assign wmask_calc = size_mask << exe_result[2:0];
   assign wdata_calc = store_data << {exe_result[2:0], 3'b000};

`ifdef MEM_STAGE_MISALIGN_CHK_EN
   // Address must be a multiple of the access size
   always_comb begin
      misaligned = 1'b0;
      case (mem_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = exe_result[0];
         2'd2:    misaligned = |exe_result[1:0];
         default: misaligned = |exe_result[2:0];
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   // Byte-enable pattern for the access size before lane shifting
   always_comb begin
      size_mask = 8'h01;
      case (mem_size)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   // Bring the addressed lane down to bit 0; lanes past byte 7 shift in as zero
   assign rdata_shifted = dmem.dmem_rdata >> {off_reg, 3'b000};

   // One extension candidate per access size: keep the low bytes, fill above
   // with the sign bit unless the load is unsigned
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_ext
         localparam int          WIDTH    = 8 << gi;
         localparam logic [63:0] LOW_MASK = 64'((65'd1 << WIDTH) - 65'd1);
         logic sign_bit;
         assign sign_bit    = ~uns_reg & rdata_shifted[WIDTH-1];
         assign ext_data[gi] = (rdata_shifted & LOW_MASK) | (sign_bit ? ~LOW_MASK : 64'd0);
      end
   endgenerate

   assign load_data = ext_data[size_reg];

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state and datapath next values; wb_valid/misalign pulse by default-0
   always_comb begin
      state_next      = state_reg;
      req_next        = req_reg;
      we_next         = we_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      wmask_next      = wmask_reg;
      off_next        = off_reg;
      size_next       = size_reg;
      uns_next        = uns_reg;
      rd_addr_next    = rd_addr_reg;
      rd_wen_next     = rd_wen_reg;
      wb_valid_next   = 1'b0;
      wb_rd_addr_next = wb_rd_addr_reg;
      wb_rd_wen_next  = wb_rd_wen_reg;
      wb_rd_data_next = wb_rd_data_reg;
      misalign_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (!is_mem) begin
                  wb_valid_next   = 1'b1;
                  wb_rd_addr_next = rd_addr;
                  wb_rd_wen_next  = rd_wen;
                  wb_rd_data_next = exe_result;
               end else if (misaligned) begin
                  wb_valid_next   = 1'b1;
                  wb_rd_addr_next = rd_addr;
                  wb_rd_wen_next  = 1'b0;
                  wb_rd_data_next = 64'd0;
                  misalign_next   = 1'b1;
               end else begin
                  // mem_wen wins when both enables are set
                  state_next   = BUSY;
                  req_next     = 1'b1;
                  we_next      = mem_wen;
                  addr_next    = {exe_result[63:3], 3'b000};
                  wdata_next   = mem_wen ? wdata_calc : 64'd0;
                  wmask_next   = mem_wen ? wmask_calc : 8'h00;
                  off_next     = exe_result[2:0];
                  size_next    = mem_size;
                  uns_next     = mem_unsigned;
                  rd_addr_next = rd_addr;
                  rd_wen_next  = rd_wen;
               end
            end
         end
         BUSY: begin
            if (dmem.dmem_ack) begin
               state_next      = IDLE;
               req_next        = 1'b0;
               wb_valid_next   = 1'b1;
               wb_rd_addr_next = rd_addr_reg;
               wb_rd_wen_next  = rd_wen_reg & ~we_reg;
               wb_rd_data_next = we_reg ? 64'd0 : load_data;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers; reset drops any outstanding request immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_reg        <= 1'b0;
         we_reg         <= 1'b0;
         addr_reg       <= 64'd0;
         wdata_reg      <= 64'd0;
         wmask_reg      <= 8'h00;
         off_reg        <= 3'd0;
         size_reg       <= 2'd0;
         uns_reg        <= 1'b0;
         rd_addr_reg    <= 5'd0;
         rd_wen_reg     <= 1'b0;
         wb_valid_reg   <= 1'b0;
         wb_rd_addr_reg <= 5'd0;
         wb_rd_wen_reg  <= 1'b0;
         wb_rd_data_reg <= 64'd0;
         misalign_reg   <= 1'b0;
      end else begin
         req_reg        <= req_next;
         we_reg         <= we_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         wmask_reg      <= wmask_next;
         off_reg        <= off_next;
         size_reg       <= size_next;
         uns_reg        <= uns_next;
         rd_addr_reg    <= rd_addr_next;
         rd_wen_reg     <= rd_wen_next;
         wb_valid_reg   <= wb_valid_next;
         wb_rd_addr_reg <= wb_rd_addr_next;
         wb_rd_wen_reg  <= wb_rd_wen_next;
         wb_rd_data_reg <= wb_rd_data_next;
         misalign_reg   <= misalign_next;
      end
   end

   assign in_ready        = (state_reg == IDLE);
   assign dmem.dmem_req   = req_reg;
   assign dmem.dmem_we    = we_reg;
   assign dmem.dmem_addr  = addr_reg;
   assign dmem.dmem_wdata = wdata_reg;
   assign dmem.dmem_wmask = wmask_reg;
   assign wb_valid        = wb_valid_reg;
   assign wb_rd_addr      = wb_rd_addr_reg;
   assign wb_rd_wen       = wb_rd_wen_reg;
   assign wb_rd_data      = wb_rd_data_reg;
   assign mem_misalign    = misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback records
// and expected memory requests; a responder process answers requests and a
// monitor process checks every wb_valid against the expected queue.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] exe_result;
   logic [63:0] store_data;
   logic        mem_ren;
   logic        mem_wen;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [4:0]  rd_addr;
   logic        rd_wen;
   logic        wb_valid;
   logic [4:0]  wb_rd_addr;
   logic        wb_rd_wen;
   logic [63:0] wb_rd_data;
   logic        mem_misalign;

   logic        resp_ack   = 1'b0;
   logic        stray_ack  = 1'b0;
   logic [63:0] resp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;

   mem_stage_if dmem_bus ();
   assign dmem_bus.dmem_ack   = resp_ack | stray_ack;
   assign dmem_bus.dmem_rdata = resp_rdata;

   mem_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .exe_result   (exe_result),
      .store_data   (store_data),
      .mem_ren      (mem_ren),
      .mem_wen      (mem_wen),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .rd_addr      (rd_addr),
      .rd_wen       (rd_wen),
      .dmem         (dmem_bus),
      .wb_valid     (wb_valid),
      .wb_rd_addr   (wb_rd_addr),
      .wb_rd_wen    (wb_rd_wen),
      .wb_rd_data   (wb_rd_data),
      .mem_misalign (mem_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic        wen;
      logic [63:0] data;
      logic        mis;
      int          cyc;
   } wb_t;

   typedef struct {
      logic [63:0] addr;
      logic        we;
      logic [7:0]  mask;
      logic [63:0] wdata;
      int          k;
      logic [63:0] rdata;
   } rsp_t;

   wb_t  wb_q[$];
   rsp_t rsp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Offer one operation, wait (bounded) for the handshake, and push the
   // expected writeback due lat negedges after acceptance (lat<0: none)
   task automatic issue(input logic [63:0] res, input logic [63:0] sd,
                        input logic ren, input logic wen, input logic [1:0] sz,
                        input logic uns, input logic [4:0] rd, input logic rwen,
                        input logic [63:0] exp_data, input logic exp_wen,
                        input logic exp_mis, input int lat, output int acc);
      bit got = 0;
      acc = -1;
      @(negedge clk);
      exe_result = res; store_data = sd; mem_ren = ren; mem_wen = wen;
      mem_size = sz; mem_unsigned = uns; rd_addr = rd; rd_wen = rwen;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         if (in_ready) begin
            @(posedge clk);
            got = 1;
            acc = cyc;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
      else if (lat >= 0) wb_q.push_back('{rd, exp_wen, exp_data, exp_mis, acc + lat});
      #1;
      in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
   endtask

   // Memory responder: check each request against the expected queue, hold
   // checks while waiting, then ack after k wait cycles
   rsp_t cur;
   bit   active = 0;
   int   cnt    = 0;
   always @(negedge clk) begin
      resp_ack   = 1'b0;
      resp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      if (rst || !dmem_bus.dmem_req) begin
         active = 0;
      end else begin
         if (!active) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_req", {63'd0, dmem_bus.dmem_req}, 64'd0);
            end else begin
               cur    = rsp_q.pop_front();
               active = 1;
               cnt    = cur.k;
               $display("req: addr=%h we=%0d wmask=%h wdata=%h", dmem_bus.dmem_addr,
                        dmem_bus.dmem_we, dmem_bus.dmem_wmask, dmem_bus.dmem_wdata);
            end
         end
         if (active) begin
            chk("dmem_addr", dmem_bus.dmem_addr, cur.addr);
            chk("dmem_we", {63'd0, dmem_bus.dmem_we}, {63'd0, cur.we});
            chk("dmem_wmask", {56'd0, dmem_bus.dmem_wmask}, {56'd0, cur.mask});
            if (cur.we) chk("dmem_wdata", dmem_bus.dmem_wdata, cur.wdata);
            if (cnt == 0) begin
               resp_ack   = 1'b1;
               resp_rdata = cur.rdata;
               active     = 0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // Monitor: pop and compare on every writeback pulse
   wb_t e;
   always @(negedge clk) begin
      cyc++;
      if (!rst && wb_valid) begin
         if (wb_q.size() == 0) begin
            chk("unexpected_wb", {63'd0, wb_valid}, 64'd0);
         end else begin
            e = wb_q.pop_front();
            $display("wb: rd=%0d wen=%0d data=%h misalign=%0d", wb_rd_addr, wb_rd_wen,
                     wb_rd_data, mem_misalign);
            chk("wb_cycle", 64'(cyc), 64'(e.cyc));
            if (!e.mis) chk("wb_rd_addr", {59'd0, wb_rd_addr}, {59'd0, e.rd});
            chk("wb_rd_wen", {63'd0, wb_rd_wen}, {63'd0, e.wen});
            chk("wb_rd_data", wb_rd_data, e.data);
            chk("mem_misalign", {63'd0, mem_misalign}, {63'd0, e.mis});
         end
      end else if (!rst && mem_misalign) begin
         chk("misalign_without_wb", {63'd0, mem_misalign}, 64'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, macc;
      rst = 1'b1; in_valid = 1'b0; exe_result = '0; store_data = '0;
      mem_ren = 1'b0; mem_wen = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
      rd_addr = '0; rd_wen = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_dmem_req", {63'd0, dmem_bus.dmem_req}, 64'd0);
      chk("rst_dmem_we", {63'd0, dmem_bus.dmem_we}, 64'd0);
      chk("rst_dmem_addr", dmem_bus.dmem_addr, 64'd0);
      chk("rst_dmem_wdata", dmem_bus.dmem_wdata, 64'd0);
      chk("rst_dmem_wmask", {56'd0, dmem_bus.dmem_wmask}, 64'd0);
      chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("rst_wb_rd_addr", {59'd0, wb_rd_addr}, 64'd0);
      chk("rst_wb_rd_wen", {63'd0, wb_rd_wen}, 64'd0);
      chk("rst_wb_rd_data", wb_rd_data, 64'd0);
      chk("rst_mem_misalign", {63'd0, mem_misalign}, 64'd0);
      rst = 1'b0;

      // ALU pass-through with a stray ack while idle (must be ignored)
      stray_ack = 1'b1;
      issue(64'h1234, 64'd0, 0, 0, 2'd0, 0, 5'd5, 1, 64'h1234, 1, 0, 1, acc);
      stray_ack = 1'b0;
      @(negedge clk);
      chk("alu_in_ready", {63'd0, in_ready}, 64'd1);

      // Signed byte load, 3 wait cycles; in_ready low through the ack cycle
      rsp_q.push_back('{64'h1000, 1'b0, 8'h00, 64'd0, 3, 64'h0000_0000_8000_0000});
      issue(64'h1003, 64'd0, 1, 0, 2'd0, 0, 5'd7, 1, 64'hFFFF_FFFF_FFFF_FF80, 1, 0, 5, acc);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
         chk("busy_dmem_req", {63'd0, dmem_bus.dmem_req}, 64'd1);
      end
      @(negedge clk);
      chk("post_ack_in_ready", {63'd0, in_ready}, 64'd1);

      // Half store at byte 6, zero-wait ack
      rsp_q.push_back('{64'h2000, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000, 0, 64'd0});
      issue(64'h2006, 64'hABCD, 0, 1, 2'd1, 0, 5'd9, 1, 64'd0, 0, 0, 2, acc);

      // Misaligned word load at 0x2002
`ifdef MEM_STAGE_MISALIGN_CHK_EN
      issue(64'h2002, 64'd0, 1, 0, 2'd2, 0, 5'd10, 1, 64'd0, 0, 1, 1, acc);
`else
      rsp_q.push_back('{64'h2000, 1'b0, 8'h00, 64'd0, 0, 64'h0000_CAFE_BABE_0000});
      issue(64'h2002, 64'd0, 1, 0, 2'd2, 0, 5'd10, 1, 64'hFFFF_FFFF_CAFE_BABE, 1, 0, 2, acc);
`endif

      // Unsigned half load from the top lane, 1 wait cycle
      rsp_q.push_back('{64'h4000, 1'b0, 8'h00, 64'd0, 1, 64'hBEEF_0000_0000_0000});
      issue(64'h4006, 64'd0, 1, 0, 2'd1, 1, 5'd11, 1, 64'h0000_0000_0000_BEEF, 1, 0, 3, acc);

      // Word store with both enables set (treated as a store), 2 wait cycles
      rsp_q.push_back('{64'h6000, 1'b1, 8'hF0, 64'hCAFE_F00D_0000_0000, 2, 64'd0});
      issue(64'h6004, 64'hDEAD_BEEF_CAFE_F00D, 1, 1, 2'd2, 0, 5'd14, 1, 64'd0, 0, 0, 4, acc);

      // Double store at offset 5: misaligned, or lanes past byte 7 dropped
`ifdef MEM_STAGE_MISALIGN_CHK_EN
      issue(64'h3005, 64'h1122_3344_5566_7788, 0, 1, 2'd3, 0, 5'd15, 1, 64'd0, 0, 1, 1, acc);
`else
      rsp_q.push_back('{64'h3000, 1'b1, 8'hE0, 64'h6677_8800_0000_0000, 0, 64'd0});
      issue(64'h3005, 64'h1122_3344_5566_7788, 0, 1, 2'd3, 0, 5'd15, 1, 64'd0, 0, 0, 2, acc);
`endif

      // Back-to-back: ALU op waits behind a 2-wait double load
      rsp_q.push_back('{64'h5000, 1'b0, 8'h00, 64'd0, 2, 64'h8000_0000_0000_0001});
      issue(64'h5000, 64'd0, 1, 0, 2'd3, 0, 5'd12, 1, 64'h8000_0000_0000_0001, 1, 0, 4, macc);
      issue(64'h77, 64'd0, 0, 0, 2'd0, 0, 5'd13, 1, 64'h77, 1, 0, 1, acc);
      chk("b2b_accept_cycle", 64'(acc), 64'(macc + 4));

      // Reset in the middle of a long transaction
      rsp_q.push_back('{64'h7000, 1'b0, 8'h00, 64'd0, 10, 64'h1});
      issue(64'h7000, 64'd0, 1, 0, 2'd3, 0, 5'd16, 1, 64'd0, 0, 0, -1, acc);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_dmem_req", {63'd0, dmem_bus.dmem_req}, 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("midrst_wb_valid", {63'd0, wb_valid}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("postrst_dmem_req", {63'd0, dmem_bus.dmem_req}, 64'd0);

      // Pass-through after reset
      issue(64'hFEED, 64'd0, 0, 0, 2'd0, 0, 5'd31, 1, 64'hFEED, 1, 0, 1, acc);

      for (int i = 0; i < 20 && wb_q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
      chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
